// File: rtl/combo_lock_pkg.sv
// Shared state encodings, digit limit and code-width helper for the combination lock.
package combo_lock_pkg;
  localparam logic [2:0] ST_LOCKED  = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_PROG    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic int code_w(input int digits);
    return 4 * digits;
  endfunction
endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock, lockout and entry-timeout intervals.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry, code check, unlock/lockout timing, reprogramming.
// Optional build macro COMBO_LOCK_MASTER_CODE_EN adds a MASTER_CODE accepted in CHECK.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int          CODE_DIGITS    = 4,
  parameter logic [15:0] DEFAULT_CODE   = 16'h0000,
  parameter int          MAX_ERR        = 3,
  parameter int          UNLOCK_CYCLES  = 50_000_000,
  parameter int          LOCKOUT_CYCLES = 500_000_000,
`ifdef COMBO_LOCK_MASTER_CODE_EN
  parameter logic [15:0] MASTER_CODE    = 16'h1234,
`endif
  parameter int          ENTRY_TIMEOUT  = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       alarm,
  output logic       bad_code,
  output logic       prog_active,
  output logic [2:0] digit_cnt,
  output logic [1:0] err_cnt,
  output logic [2:0] state
);
  localparam int CW    = code_w(CODE_DIGITS);
  localparam int MAXC0 = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAXC  = (MAXC0 > ENTRY_TIMEOUT) ? MAXC0 : ENTRY_TIMEOUT;
  localparam int TW    = $clog2(MAXC + 1);
  // Load N-1 so the owning state lasts exactly N cycles including the one that sees zero.
  localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LD   = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [2:0]    CNT_FULL   = 3'(CODE_DIGITS);
  localparam logic [1:0]    ERR_LIM    = 2'(MAX_ERR);

  logic [2:0]    r_state, w_nxt;
  logic [CW-1:0] r_buf, w_buf_nxt, w_shift;
  logic [CW-1:0] r_code, w_code_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]    r_err, w_err_nxt, w_err_inc;
  logic          r_bad, w_bad_nxt;
  logic          w_tload, w_expired, w_is_digit, w_match;
  logic [TW-1:0] w_tval;

  lock_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tload),
    .i_load_val (w_tval),
    .o_expired  (w_expired)
  );

  assign w_is_digit = (digit <= DIGIT_MAX);
  assign w_shift    = CW'({r_buf, digit});
  assign w_cnt_inc  = r_cnt + 3'd1;
  assign w_err_inc  = r_err + 2'd1;
`ifdef COMBO_LOCK_MASTER_CODE_EN
  assign w_match = (r_buf == r_code) || (r_buf == MASTER_CODE[CW-1:0]);
`else
  assign w_match = (r_buf == r_code);
`endif

  always_comb begin
    w_nxt      = r_state;
    w_buf_nxt  = r_buf;
    w_code_nxt = r_code;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_err;
    w_bad_nxt  = 1'b0;
    w_tload    = 1'b0;
    w_tval     = ENTRY_LD;
    case (r_state)
      ST_LOCKED: begin
        if (digit_valid && w_is_digit) begin
          w_buf_nxt = w_shift;
          w_cnt_nxt = 3'd1;
          w_tload   = 1'b1;
          w_nxt     = (CNT_FULL == 3'd1) ? ST_CHECK : ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (digit_valid && w_is_digit) begin
          w_buf_nxt = w_shift;
          w_cnt_nxt = w_cnt_inc;
          w_tload   = 1'b1;
          if (w_cnt_inc == CNT_FULL) w_nxt = ST_CHECK;
        end else if (digit_valid || w_expired) begin
          w_nxt     = ST_LOCKED;
          w_buf_nxt = '0;
          w_cnt_nxt = 3'd0;
        end
      end
      ST_CHECK: begin
        w_buf_nxt = '0;
        w_cnt_nxt = 3'd0;
        if (w_match) begin
          w_err_nxt = 2'd0;
          w_tload   = 1'b1;
          w_tval    = UNLOCK_LD;
          w_nxt     = ST_OPEN;
        end else if (w_err_inc >= ERR_LIM) begin
          w_err_nxt = ERR_LIM;
          w_tload   = 1'b1;
          w_tval    = LOCKOUT_LD;
          w_nxt     = ST_LOCKOUT;
        end else begin
          w_err_nxt = w_err_inc;
          w_bad_nxt = 1'b1;
          w_nxt     = ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (prog_req) begin
          w_nxt     = ST_PROG;
          w_cnt_nxt = 3'd0;
          w_buf_nxt = '0;
          w_tload   = 1'b1;
        end else if (w_expired) begin
          w_nxt = ST_LOCKED;
        end
      end
      ST_PROG: begin
        // The entry buffer doubles as the shadow; usr_code only changes on the final digit.
        if (prog_req && digit_valid && w_is_digit) begin
          w_cnt_nxt = w_cnt_inc;
          w_tload   = 1'b1;
          if (w_cnt_inc == CNT_FULL) begin
            w_code_nxt = w_shift;
            w_buf_nxt  = '0;
            w_cnt_nxt  = 3'd0;
            w_nxt      = ST_LOCKED;
          end else begin
            w_buf_nxt = w_shift;
          end
        end else if (!prog_req || digit_valid || w_expired) begin
          w_nxt     = ST_LOCKED;
          w_buf_nxt = '0;
          w_cnt_nxt = 3'd0;
        end
      end
      ST_LOCKOUT: begin
        if (w_expired) begin
          w_err_nxt = 2'd0;
          w_nxt     = ST_LOCKED;
        end
      end
      default: begin
        w_nxt     = ST_LOCKED;
        w_buf_nxt = '0;
        w_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCKED;
      r_buf   <= '0;
      r_code  <= DEFAULT_CODE[CW-1:0];
      r_cnt   <= 3'd0;
      r_err   <= 2'd0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_buf   <= w_buf_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  assign state       = r_state;
  assign unlocked    = (r_state == ST_OPEN) || (r_state == ST_PROG);
  assign alarm       = (r_state == ST_LOCKOUT);
  assign prog_active = (r_state == ST_PROG);
  assign bad_code    = r_bad;
  assign digit_cnt   = r_cnt;
  assign err_cnt     = r_err;
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed table-driven bench for combo_lock_ctrl with short interval parameters.
module tb_combo_lock_ctrl;
  logic       clk = 1'b0;
  logic       reset, digit_valid, prog_req;
  logic [3:0] digit;
  logic       unlocked, alarm, bad_code, prog_active;
  logic [2:0] digit_cnt, state;
  logic [1:0] err_cnt;

  localparam logic [2:0] L = 3'd0, E = 3'd1, C = 3'd2, O = 3'd3, P = 3'd4, X = 3'd5;

  combo_lock_ctrl #(
    .CODE_DIGITS(4), .DEFAULT_CODE(16'h0000), .MAX_ERR(3),
    .UNLOCK_CYCLES(20), .LOCKOUT_CYCLES(30), .ENTRY_TIMEOUT(10)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .prog_req(prog_req), .unlocked(unlocked), .alarm(alarm), .bad_code(bad_code),
    .prog_active(prog_active), .digit_cnt(digit_cnt), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  d;
    logic        pr;
    logic [11:0] exp;
  } vec_t;

  vec_t tv[$];
  int   vi = 0;
  int   n_chk = 0, n_pass = 0;

  // {state, unlocked, alarm, bad_code, prog_active, digit_cnt, err_cnt}
  function automatic logic [11:0] outs();
    return {state, unlocked, alarm, bad_code, prog_active, digit_cnt, err_cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic dv, input logic [3:0] d, input logic pr,
                     input logic [2:0] st, input logic unl, input logic alm,
                     input logic bad, input logic pa, input logic [2:0] dc,
                     input logic [1:0] ec);
    vec_t v;
    v.dv = dv; v.d = d; v.pr = pr;
    v.exp = {st, unl, alm, bad, pa, dc, ec};
    tv.push_back(v);
  endtask

  // Four-digit entry from LOCKED: three ENTRY steps then CHECK with digit_cnt=4.
  task automatic code4(input logic [15:0] c, input logic [1:0] ec, input logic pr);
    for (int i = 0; i < 4; i++)
      add(1'b1, c[15-4*i -: 4], pr, (i == 3) ? C : E, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i + 1), ec);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cnt, input string seg);
    for (int i = 0; i < cnt; i++) begin
      digit_valid = tv[vi].dv;
      digit       = tv[vi].d;
      prog_req    = tv[vi].pr;
      tick();
      chk($sformatf("%s[%0d]", seg, i), 32'(outs()), 32'(tv[vi].exp));
      vi++;
    end
    digit_valid = 1'b0;
    digit       = 4'd0;
    prog_req    = 1'b0;
  endtask

  task automatic hit_reset(input string nm);
    #2;
    reset = 1'b1;
    #1;
    chk(nm, 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk({nm, "_after"}, 32'(outs()), 32'd0);
  endtask

  task automatic wait_open_end(input string nm);
    int n = 0;
    while (unlocked && n < 100) begin
      n++;
      tick();
    end
    chk({nm, "_len"}, 32'(n), 32'd20);
    chk({nm, "_state"}, 32'(state), 32'(L));
  endtask

  initial begin
    int  n;
    logic bad_seen;
    reset = 1'b1; digit_valid = 1'b0; digit = 4'd0; prog_req = 1'b0;

    // seg1: default code opens (5)
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 0, O, 1, 0, 0, 0, 3'd0, 2'd0);
    // seg2: three wrong codes, the third locks out (17)
    for (int k = 0; k < 2; k++) begin
      code4(16'h1234, 2'(k), 1'b0);
      add(0, 0, 0, L, 0, 0, 1, 0, 3'd0, 2'(k + 1));
      add(0, 0, 0, L, 0, 0, 0, 0, 3'd0, 2'(k + 1));
    end
    code4(16'h1234, 2'd2, 1'b0);
    add(0, 0, 0, X, 0, 1, 0, 0, 3'd0, 2'd3);
    // seg3: open, program 5678, old code fails, new code opens (20)
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 1, O, 1, 0, 0, 0, 3'd0, 2'd0);
    add(0, 0, 1, P, 1, 0, 0, 1, 3'd0, 2'd0);
    add(1, 5, 1, P, 1, 0, 0, 1, 3'd1, 2'd0);
    add(1, 6, 1, P, 1, 0, 0, 1, 3'd2, 2'd0);
    add(1, 7, 1, P, 1, 0, 0, 1, 3'd3, 2'd0);
    add(1, 8, 1, L, 0, 0, 0, 0, 3'd0, 2'd0);
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 0, L, 0, 0, 1, 0, 3'd0, 2'd1);
    code4(16'h5678, 2'd1, 1'b0);
    add(0, 0, 0, O, 1, 0, 0, 0, 3'd0, 2'd0);
    // seg4: after reset, programming aborted by prog_req drop keeps 0000 (14)
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 1, O, 1, 0, 0, 0, 3'd0, 2'd0);
    add(0, 0, 1, P, 1, 0, 0, 1, 3'd0, 2'd0);
    add(1, 1, 1, P, 1, 0, 0, 1, 3'd1, 2'd0);
    add(1, 2, 1, P, 1, 0, 0, 1, 3'd2, 2'd0);
    add(0, 0, 0, L, 0, 0, 0, 0, 3'd0, 2'd0);
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 0, O, 1, 0, 0, 0, 3'd0, 2'd0);
    // seg5: one wrong code, then abort with A keeps err_cnt, then start a timeout (9)
    code4(16'h1234, 2'd0, 1'b0);
    add(0, 0, 0, L, 0, 0, 1, 0, 3'd0, 2'd1);
    add(1, 1, 0, E, 0, 0, 0, 0, 3'd1, 2'd1);
    add(1, 2, 0, E, 0, 0, 0, 0, 3'd2, 2'd1);
    add(1, 4'hA, 0, L, 0, 0, 0, 0, 3'd0, 2'd1);
    add(1, 1, 0, E, 0, 0, 0, 0, 3'd1, 2'd1);
    // seg6: two more wrong codes reach lockout (10)
    code4(16'h1234, 2'd1, 1'b0);
    add(0, 0, 0, L, 0, 0, 1, 0, 3'd0, 2'd2);
    code4(16'h1234, 2'd2, 1'b0);
    add(0, 0, 0, X, 0, 1, 0, 0, 3'd0, 2'd3);
    // seg7: after reset in lockout the default code opens at once (5)
    code4(16'h0000, 2'd0, 1'b0);
    add(0, 0, 0, O, 1, 0, 0, 0, 3'd0, 2'd0);

    tick();
    tick();
    chk("reset_held", 32'(outs()), 32'd0);
    reset = 1'b0;
    tick();
    chk("reset_idle", 32'(outs()), 32'd0);

    run(5, "open_default");
    wait_open_end("unlock1");

    run(17, "wrong_codes");
    n = 1; bad_seen = 1'b0;
    while (alarm && n < 100) begin
      digit_valid = (n <= 8);
      digit       = 4'd0;
      tick();
      if (bad_code) bad_seen = 1'b1;
      if (alarm) n++;
    end
    digit_valid = 1'b0;
    chk("lockout_len", 32'(n), 32'd30);
    chk("lockout_no_bad", 32'(bad_seen), 32'd0);
    chk("lockout_exit", 32'(outs()), 32'd0);

    run(20, "program");
    hit_reset("rst_open");

    run(14, "prog_abort");
    wait_open_end("unlock2");

    run(9, "entry_abort");
    repeat (9) tick();
    chk("timeout_hold", 32'(state), 32'(E));
    tick();
    chk("timeout_abort", 32'(outs()), 32'h001);

    run(10, "lockout2");
    repeat (3) tick();
    hit_reset("rst_lockout");

    run(5, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequencing controller for the FPGA combination lock. It collects debounced keypad digits into a code word and compares it against the stored user code. It drives the unlock, alarm and lockout outputs, and manages code reprogramming. It sits between the keypad debouncer (single-cycle strobes) and the lock actuator/LED outputs.

Parameters:
CODE_DIGITS, 4, number of 4-bit digits per code (1..4); code word is 4*CODE_DIGITS bits
DEFAULT_CODE, 16'h0000, user code loaded at reset (low 4*CODE_DIGITS bits used)
MAX_ERR, 3, consecutive wrong codes before lockout (1..3)
UNLOCK_CYCLES, 50_000_000, clk cycles unlocked stays high
LOCKOUT_CYCLES, 500_000_000, clk cycles of lockout/alarm
ENTRY_TIMEOUT, 250_000_000, idle clk cycles allowed between digits before entry aborts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digit_valid  in  1  one-cycle strobe: digit is valid
digit  in  4  keypad value; 0-9 are digits, A-F are clear/abort
prog_req  in  1  level; request to reprogram the code while open
unlocked  out  1  lock released
alarm  out  1  high during lockout
bad_code  out  1  one-cycle pulse on a wrong code that does not cause lockout
prog_active  out  1  high in PROG state
digit_cnt  out  3  digits captured in current entry/program sequence
err_cnt  out  2  consecutive wrong-code count
state  out  3  current FSM state encoding

Behaviour:
- Reset (async, immediate): state=LOCKED, usr_code=DEFAULT_CODE, err_cnt=0, digit_cnt=0, entry buffer=0, timer=0, all outputs 0.
- States and encodings: LOCKED=0, ENTRY=1, CHECK=2, OPEN=3, PROG=4, LOCKOUT=5. Unused encodings go to LOCKED.
- LOCKED:
  - digit_valid with digit<=9: shift the digit into the buffer (MS digit first), digit_cnt=1, go to ENTRY, load the timeout timer.
  - digit>9: ignored.
- ENTRY:
  - digit_valid with digit<=9: shift in the digit, digit_cnt+1, reload the timer.
  - When digit_cnt reaches CODE_DIGITS: go to CHECK on the next clk.
  - digit>9, or timer expiry: go to LOCKED, clear buffer and digit_cnt. err_cnt is unchanged.
- CHECK (exactly 1 cycle; digit_valid ignored):
  - Match: err_cnt=0, go to OPEN, load UNLOCK_CYCLES. unlocked is high the cycle after CHECK, i.e. 2 clks after the last digit strobe.
  - Mismatch with err_cnt+1<MAX_ERR: err_cnt+1, bad_code pulses for 1 cycle, go to LOCKED.
  - Mismatch with err_cnt+1==MAX_ERR: go to LOCKOUT, load LOCKOUT_CYCLES, err_cnt=MAX_ERR.
- OPEN:
  - unlocked=1 for exactly UNLOCK_CYCLES cycles, then go to LOCKED.
  - prog_req high while in OPEN: go to PROG, digit_cnt=0, unlocked stays 1, timer is replaced by ENTRY_TIMEOUT.
- PROG:
  - Digits shift into a shadow buffer.
  - When CODE_DIGITS digits are captured: usr_code is updated atomically from the shadow buffer, then go to LOCKED.
  - prog_req deassert, digit>9, or timeout: abort to LOCKED; usr_code unchanged.
- LOCKOUT:
  - alarm=1. All input is ignored for LOCKOUT_CYCLES cycles.
  - On expiry: err_cnt=0, go to LOCKED.
- Timer is a single down-counter, 0 means expired. Its width is clog2 of the largest cycle parameter.
- Reset mid-operation aborts everything. Any programmed code is lost and returns to DEFAULT_CODE.

Optional Feature:
COMBO_LOCK_MASTER_CODE_EN
- Defined: adds parameter MASTER_CODE (default 16'h1234). In CHECK, a match against MASTER_CODE also opens the lock and clears err_cnt. Master code is not accepted during LOCKOUT.
- Undefined: only usr_code is compared; no extra logic.

Decomposition:
- Package combo_lock_pkg holds:
  - state enum and encodings
  - DIGIT_MAX=4'd9
  - code-width helper function
- Natural sub-module: lock_timer, a loadable down-counter with load, load_val and expired. It is shared for the unlock, lockout and entry-timeout intervals.

Test Plan:
- Reset, enter 0,0,0,0 (DEFAULT_CODE) -> unlocked=1 2 clks after 4th strobe, stays high exactly UNLOCK_CYCLES (bench sets 20), err_cnt=0.
- Enter 1,2,3,4 twice -> bad_code pulses twice, err_cnt=2. Third wrong code -> alarm=1 for LOCKOUT_CYCLES (bench 30), no bad_code, digits ignored, then err_cnt=0.
- Open, assert prog_req, enter 5,6,7,8 -> LOCKED. Then 0,0,0,0 fails and 5,6,7,8 unlocks.
- In PROG after 2 digits, drop prog_req -> LOCKED; old code 0000 still unlocks.
- Enter 1,2, then digit A -> LOCKED, digit_cnt=0, err_cnt unchanged. Enter 1, then idle past ENTRY_TIMEOUT (bench 10) -> LOCKED.
- Assert reset during OPEN and during LOCKOUT -> outputs 0 immediately, state=0, code back to 0000.
